// File: rtl/membrane_integrator.sv
// Hodgkin-Huxley membrane-potential integrator.
// Each accepted step walks a fixed 10-state sequence that builds I_K, I_Na and
// I_L from the captured gate values, then Euler-updates the fine potential.
// Upward crossings of the threshold are flagged and counted.
module membrane_integrator #(
  parameter int GNA      = 120,
  parameter int GK       = 36,
  parameter int GL_X1000 = 300,
  parameter int ENA      = 50,
  parameter int EK       = -77,
  parameter int EL       = -54,
  parameter int V_REST   = -65,
  parameter int V_TH     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gates_valid,
  input  logic signed [15:0] n,
  input  logic signed [15:0] m,
  input  logic signed [15:0] h,
  input  logic signed [15:0] dt,
  input  logic signed [31:0] i_ext,
  output logic signed [15:0] V,
  output logic               v_valid,
  output logic               busy,
  output logic               spike,
  output logic        [15:0] spike_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_N2, S_N4, S_IK, S_M2, S_M3, S_M3H, S_INA, S_IL, S_SUM, S_UPD
  } state_t;

  localparam logic signed [47:0] P_K1000   = 48'sd1000;
  localparam logic signed [47:0] P_VMAX    = 48'sd60000;
  localparam logic signed [47:0] P_VMIN    = -48'sd100000;
  localparam logic signed [47:0] P_GNA     = 48'(GNA);
  localparam logic signed [47:0] P_GK      = 48'(GK);
  localparam logic signed [47:0] P_GL      = 48'(GL_X1000);
  localparam logic signed [47:0] P_ENA     = 48'(ENA);
  localparam logic signed [47:0] P_EK      = 48'(EK);
  localparam logic signed [47:0] P_EL      = 48'(EL);
  localparam logic signed [15:0] P_VTH     = 16'(V_TH);
  localparam logic signed [15:0] P_VRST    = 16'(V_REST);
  localparam logic signed [31:0] P_VFRST   = 32'(V_REST * 1000);

  // Sign-extend to the common 48-bit product width.
  function automatic logic signed [47:0] sx16(input logic signed [15:0] x);
    return {{32{x[15]}}, x};
  endfunction

  function automatic logic signed [47:0] sx32(input logic signed [31:0] x);
    return {{16{x[31]}}, x};
  endfunction

  // Gate values are probabilities scaled x1000; anything outside is clipped.
  function automatic logic signed [15:0] clamp_gate(input logic signed [15:0] x);
    if (x < 16'sd0)    return 16'sd0;
    if (x > 16'sd1000) return 16'sd1000;
    return x;
  endfunction

  state_t r_state, w_next;

  // Captured step operands.
  logic signed [15:0] r_n, r_m, r_h, r_dt, r_vc;
  logic signed [31:0] r_iext;
  // Intermediate gate powers and currents.
  logic signed [31:0] r_n2, r_n4, r_m2, r_m3, r_m3h;
  logic signed [31:0] r_ik, r_ina, r_il, r_isum;
  // Membrane state.
  logic signed [31:0] r_vfine;
  logic signed [15:0] r_V;
  logic               r_vvalid, r_spike;
  logic        [15:0] r_spk_cnt;
  logic               w_busy;

  logic signed [47:0] w_n2, w_n4, w_m2, w_m3, w_m3h;
  logic signed [47:0] w_ik, w_ina, w_il;
  logic signed [47:0] w_dv, w_vsum, w_vclamp, w_vnew48;
  logic signed [15:0] w_vnew;
  logic               w_cross;
  logic               w_unused;

  // Per-state arithmetic; each result is latched when its state is left.
  assign w_n2   = (sx16(r_n) * sx16(r_n)) / P_K1000;
  assign w_n4   = (sx32(r_n2) * sx32(r_n2)) / P_K1000;
  assign w_ik   = P_GK * sx32(r_n4) * (sx16(r_vc) - P_EK);
  assign w_m2   = (sx16(r_m) * sx16(r_m)) / P_K1000;
  assign w_m3   = (sx32(r_m2) * sx16(r_m)) / P_K1000;
  assign w_m3h  = (sx32(r_m3) * sx16(r_h)) / P_K1000;
  assign w_ina  = P_GNA * sx32(r_m3h) * (sx16(r_vc) - P_ENA);
  assign w_il   = P_GL * (sx16(r_vc) - P_EL);

  // Euler update; a non-positive dt leaves the potential where it is.
  assign w_dv     = (r_dt > 16'sd0) ? (sx32(r_isum) * sx16(r_dt)) / P_K1000 : 48'sd0;
  assign w_vsum   = sx32(r_vfine) + w_dv;
  assign w_vclamp = (w_vsum > P_VMAX) ? P_VMAX :
                    (w_vsum < P_VMIN) ? P_VMIN : w_vsum;
  assign w_vnew48 = w_vclamp / P_K1000;
  assign w_vnew   = w_vnew48[15:0];
  assign w_cross  = (r_V < P_VTH) && (w_vnew >= P_VTH);

  // Upper product bits are known zero/sign after range limiting.
  assign w_unused = ^{w_n2[47:32], w_n4[47:32], w_m2[47:32], w_m3[47:32],
                      w_m3h[47:32], w_ik[47:32], w_ina[47:32], w_il[47:32],
                      w_vclamp[47:32], w_vnew48[47:16]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: fixed walk through the compute states once accepted.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = gates_valid ? S_N2 : S_IDLE;
      S_N2:    w_next = S_N4;
      S_N4:    w_next = S_IK;
      S_IK:    w_next = S_M2;
      S_M2:    w_next = S_M3;
      S_M3:    w_next = S_M3H;
      S_M3H:   w_next = S_INA;
      S_INA:   w_next = S_IL;
      S_IL:    w_next = S_SUM;
      S_SUM:   w_next = S_UPD;
      S_UPD:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Datapath: capture on accept, one result per state, commit in UPD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n       <= '0;
      r_m       <= '0;
      r_h       <= '0;
      r_dt      <= '0;
      r_vc      <= '0;
      r_iext    <= '0;
      r_n2      <= '0;
      r_n4      <= '0;
      r_m2      <= '0;
      r_m3      <= '0;
      r_m3h     <= '0;
      r_ik      <= '0;
      r_ina     <= '0;
      r_il      <= '0;
      r_isum    <= '0;
      r_vfine   <= P_VFRST;
      r_V       <= P_VRST;
      r_vvalid  <= 1'b0;
      r_spike   <= 1'b0;
      r_spk_cnt <= '0;
    end else begin
      r_vvalid <= 1'b0;
      r_spike  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (gates_valid) begin
            r_n    <= clamp_gate(n);
            r_m    <= clamp_gate(m);
            r_h    <= clamp_gate(h);
            r_dt   <= dt;
            r_iext <= i_ext;
            r_vc   <= r_V;
          end
        end
        S_N2:  r_n2  <= w_n2[31:0];
        S_N4:  r_n4  <= w_n4[31:0];
        S_IK:  r_ik  <= w_ik[31:0];
        S_M2:  r_m2  <= w_m2[31:0];
        S_M3:  r_m3  <= w_m3[31:0];
        S_M3H: r_m3h <= w_m3h[31:0];
        S_INA: r_ina <= w_ina[31:0];
        S_IL:  r_il  <= w_il[31:0];
        S_SUM: r_isum <= r_iext - r_ina - r_ik - r_il;
        S_UPD: begin
          r_vfine  <= w_vclamp[31:0];
          r_V      <= w_vnew;
          r_vvalid <= 1'b1;
          if (w_cross) begin
            r_spike   <= 1'b1;
            r_spk_cnt <= r_spk_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign V           = r_V;
  assign v_valid     = r_vvalid;
  assign busy        = w_busy;
  assign spike       = r_spike;
  assign spike_count = r_spk_cnt;

endmodule

// File: tb/tb_membrane_integrator.sv
// Directed bench for membrane_integrator with hand-computed expectations.
module tb_membrane_integrator;

  logic               clk = 1'b0;
  logic               reset;
  logic               gates_valid;
  logic signed [15:0] n, m, h, dt;
  logic signed [31:0] i_ext;
  logic signed [15:0] V;
  logic               v_valid, busy, spike;
  logic        [15:0] spike_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int vv_cnt = 0;
  int vv_last = 0;
  int vv_prev = 0;

  membrane_integrator dut (
    .clk(clk), .reset(reset), .gates_valid(gates_valid),
    .n(n), .m(m), .h(h), .dt(dt), .i_ext(i_ext),
    .V(V), .v_valid(v_valid), .busy(busy), .spike(spike),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count v_valid pulses and remember the cycle of the last two.
  always @(negedge clk) begin
    if (v_valid) begin
      vv_cnt  = vv_cnt + 1;
      vv_prev = vv_last;
      vv_last = cyc;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One step: accept at edge k, wait (bounded) for v_valid; report latency and spike.
  task automatic run_step(input logic signed [15:0] tn, tm, th, tdt,
                          input logic signed [31:0] tie,
                          output int lat, output logic sp);
    @(negedge clk);
    n = tn; m = tm; h = th; dt = tdt; i_ext = tie;
    gates_valid = 1'b1;
    @(posedge clk);
    #1 gates_valid = 1'b0;
    lat = 0;
    sp  = 1'b0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (v_valid) begin
        sp = spike;
        break;
      end
    end
  endtask

  initial begin
    int   lat;
    logic sp;
    int   c0;
    int   guard;

    reset = 1'b1; gates_valid = 1'b0;
    n = '0; m = '0; h = '0; dt = '0; i_ext = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_V", V, -65);
    chk("rst_busy", busy, 0);
    chk("rst_vvalid", v_valid, 0);
    chk("rst_spike", spike, 0);
    chk("rst_cnt", spike_count, 0);
    @(negedge clk) reset = 1'b0;

    // Leak only: il=-3300, v_fine=-64967 -> V=-64
    run_step(16'sd0, 16'sd0, 16'sd0, 16'sd10, 32'sd0, lat, sp);
    chk("leak_lat", lat, 10);
    chk("leak_V", V, -64);
    chk("leak_busy", busy, 0);

    // dt=0 with out-of-range gates: V held, v_valid still pulses
    run_step(-16'sd5, 16'sd2000, 16'sd1000, 16'sd0, 32'sd0, lat, sp);
    chk("dt0_lat", lat, 10);
    chk("dt0_V", V, -64);
    // Negative dt with a large drive would move V to -74 if applied
    run_step(16'sd0, 16'sd0, 16'sd0, -16'sd10, 32'sd1000000, lat, sp);
    chk("dtneg_V", V, -64);

    // K current from reset: ik=432000, v_fine=-69287 -> V=-69
    do_reset();
    run_step(16'sd1000, 16'sd0, 16'sd0, 16'sd10, 32'sd0, lat, sp);
    chk("k_V", V, -69);
    // n=2000 must behave as n=1000
    do_reset();
    run_step(16'sd2000, 16'sd0, 16'sd0, 16'sd10, 32'sd0, lat, sp);
    chk("nclamp_hi_V", V, -69);
    // n=-5 must behave as n=0 (leak result)
    do_reset();
    run_step(-16'sd5, 16'sd0, 16'sd0, 16'sd10, 32'sd0, lat, sp);
    chk("nclamp_lo_V", V, -64);
    // m=2000 clipped to 1000: ina=-13800000, isum=13803300, dt=1 -> -51197 -> V=-51
    do_reset();
    run_step(16'sd0, 16'sd2000, 16'sd1000, 16'sd1, 32'sd0, lat, sp);
    chk("mclamp_V", V, -51);

    // Clamp and spike
    do_reset();
    run_step(16'sd0, 16'sd0, 16'sd0, 16'sd1000, 32'sd100000000, lat, sp);
    chk("spk1_V", V, 60);
    chk("spk1_spike", sp, 1);
    chk("spk1_cnt", spike_count, 1);
    @(posedge clk); #1;
    chk("spk1_pulse_end", spike, 0);
    run_step(16'sd0, 16'sd0, 16'sd0, 16'sd1000, 32'sd100000000, lat, sp);
    chk("spk2_V", V, 60);
    chk("spk2_spike", sp, 0);
    chk("spk2_cnt", spike_count, 1);

    // Reset at edge k+5 aborts the step (V was 60, count 1)
    @(negedge clk);
    n = '0; m = '0; h = '0; dt = 16'sd10; i_ext = '0;
    gates_valid = 1'b1;
    @(posedge clk);
    #1 gates_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_V", V, -65);
    chk("mid_busy", busy, 0);
    chk("mid_vvalid", v_valid, 0);
    chk("mid_cnt", spike_count, 0);
    @(negedge clk) reset = 1'b0;
    c0 = vv_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("mid_no_vvalid", vv_cnt - c0, 0);

    // gates_valid pulses at k+3 and k+10 are ignored
    @(negedge clk);
    gates_valid = 1'b1;
    c0 = vv_cnt;
    @(posedge clk);
    #1 gates_valid = 1'b0;
    chk("bsy_k_busy", busy, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) gates_valid = 1'b1;
    @(posedge clk);
    #1 gates_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) gates_valid = 1'b1;
    @(posedge clk);
    #1 gates_valid = 1'b0;
    chk("bsy_k10_vvalid", v_valid, 1);
    chk("bsy_k10_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("bsy_one_pulse", vv_cnt - c0, 1);
    chk("bsy_idle", busy, 0);

    // gates_valid held high: accepts every 11 cycles
    @(negedge clk);
    c0 = vv_cnt;
    gates_valid = 1'b1;
    guard = 0;
    while (vv_cnt < c0 + 2 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk) gates_valid = 1'b0;
    chk("held_pulses", (vv_cnt >= c0 + 2) ? 1 : 0, 1);
    chk("held_period", vv_last - vv_prev, 11);
    repeat (12) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/membrane_integrator.md
Name: membrane_integrator

Overview:
Hodgkin-Huxley membrane-potential integrator.
- Consumes the gate values n, m and h produced by the gate updaters, and drives V and the step strobe back to them.
- Each accepted step runs a fixed 10-cycle FSM that computes I_Na, I_K and I_L, then Euler-updates the membrane potential.
- Also detects upward threshold crossings (spikes) and counts them.

Parameters:
GNA, 120, Na max conductance, mS/cm^2
GK, 36, K max conductance, mS/cm^2
GL_X1000, 300, leak conductance, 0.001 mS/cm^2
ENA, 50, Na reversal potential, mV
EK, -77, K reversal potential, mV
EL, -54, leak reversal potential, mV
V_REST, -65, reset potential, mV
V_TH, 0, spike threshold, mV

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
gates_valid  in  1  n/m/h valid; starts a step when the block is idle
n  in  16 signed  K activation, scaled x1000
m  in  16 signed  Na activation, scaled x1000
h  in  16 signed  Na inactivation, scaled x1000
dt  in  16 signed  time step, units of 0.001 ms
i_ext  in  32 signed  injected current, 0.001 uA/cm^2
V  out  16 signed  membrane potential, whole mV
v_valid  out  1  one-cycle pulse when V is updated
busy  out  1  step in progress
spike  out  1  one-cycle pulse on an upward crossing of V_TH
spike_count  out  16  spike counter

Behaviour:
- Clock is clk. Reset is reset, asynchronous, active-high.
- Reset state:
  - v_fine = V_REST*1000 (internal 32-bit signed potential, 0.001 mV units).
  - V = V_REST.
  - v_valid, busy, spike = 0; spike_count = 0; FSM = IDLE.
  - Reset mid-step aborts the step; no partial update is kept.
- FSM states: IDLE, N2, N4, IK, M2, M3, M3H, INA, IL, SUM, UPD. Each non-IDLE state lasts one cycle, in that order, then returns to IDLE.
- Accept: at an edge where the FSM is IDLE and gates_valid=1 (call it edge k):
  - Capture n, m, h, dt, i_ext and the current V into working registers.
  - Clamp each of n, m, h to the range 0..1000 on capture.
  - Set busy=1 and go to N2.
- gates_valid while busy=1 is ignored, with no queuing.
- Arithmetic:
  - All products use at least 48-bit signed intermediates.
  - Every "/1000" is Verilog signed division, which truncates toward zero.
- Per-state computation:
  - N2: n2 = n*n/1000
  - N4: n4 = n2*n2/1000
  - IK: ik = GK*n4*(Vc-EK)
  - M2: m2 = m*m/1000
  - M3: m3 = m2*m/1000
  - M3H: m3h = m3*h/1000
  - INA: ina = GNA*m3h*(Vc-ENA)
  - IL: il = GL_X1000*(Vc-EL)
  - SUM: isum = i_ext - ina - ik - il
  - UPD: see below
- All currents are 32-bit signed, in units of 0.001 uA/cm^2. Vc is the captured V.
- UPD step:
  - If dt <= 0, v_fine is unchanged. Otherwise v_fine += isum*dt/1000.
  - Clamp v_fine to the range -100000..+60000.
  - V = v_fine/1000.
  - This happens at edge k+10.
- Also at edge k+10:
  - busy returns to 0.
  - v_valid = 1 for exactly one cycle; this happens even when dt <= 0.
  - The FSM returns to IDLE.
  - The earliest next accept is edge k+11.
- Spike detection at edge k+10:
  - Condition: old V < V_TH and new V >= V_TH.
  - Action: spike pulses for one cycle and spike_count increments.
  - spike_count wraps 0xFFFF -> 0x0000.
  - Holding above threshold does not re-fire the spike.

Test Plan:
- Reset values: assert reset mid-step (at edge k+5) -> immediately V=-65, busy=0, v_valid=0, spike_count=0; no v_valid pulse follows.
- Leak only: n=m=h=0, i_ext=0, dt=10, V=-65 -> il=-3300, isum=3300, v_fine=-64967, V=-64. v_valid pulses exactly 10 edges after accept.
- K current: n=1000, m=h=0, i_ext=0, dt=10 from reset -> ik=432000, isum=-428700, v_fine=-69287, V=-69.
- Clamp and spike: i_ext=100000000, dt=1000, gates 0 -> v_fine clamps to 60000, V=60, spike=1, spike_count=1. A second identical step keeps V=60, spike stays 0, count stays 1.
- Busy handling: pulse gates_valid at k+3 and at k+10 -> both ignored, exactly one v_valid. gates_valid held high -> accepts occur every 11 cycles.
- Input clamp and dt: n=-5, m=2000, h=1000, dt=0 -> V unchanged and v_valid still pulses. In a separate run with dt=10, n=-5 produces the same result as n=0.
